// File: rtl/elevator_call_panel.sv
// Hall and car push-button front end: synchronise, debounce, edge-detect, pulse requests and hold call lamps.
// Optional build macro CAR_CALL_CANCEL_EN: a repeat car-button press cancels that lamp instead of re-pulsing.
module elevator_call_panel #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:1] raw_up,
    input  logic [8:2] raw_dn,
    input  logic [8:1] raw_car,
    input  logic [8:1] floor,
    input  logic [1:0] state,
    output logic [7:1] btup,
    output logic [8:2] btdn,
    output logic [8:1] in_bt_floor,
    output logic [7:1] lamp_up,
    output logic [8:2] lamp_dn,
    output logic [8:1] lamp_car,
    output logic       pending
);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'b00,
        ST_DOWN    = 2'b01,
        ST_UP      = 2'b10,
        ST_CLOSING = 2'b11
    } ctrlState_e;

    // All 22 buttons live in one flat vector: up floors 1..7, down floors 2..8, car floors 1..8
    localparam int NB     = 22;
    localparam int DN_LO  = 7;
    localparam int CAR_LO = 14;

    ctrlState_e        stateIn;
    logic [NB-1:0]     rawAll;
    logic [NB-1:0]     sync1_q, sync2_q;
    logic [NB-1:0]     deb_q, deb_d, debPrev_q;
    logic [CNT_W-1:0]  cnt_q [NB];
    logic [CNT_W-1:0]  cnt_d [NB];
    logic [NB-1:0]     press, serve, cancel;
    logic [NB-1:0]     pulse_q, pulse_d;
    logic [NB-1:0]     lamp_q, lamp_d;
    logic              pending_q, pending_d;
    logic              lastDir_q, lastDir_d;
    logic [7:1]        serveUp;
    logic [8:2]        serveDn;
    logic [8:1]        serveCar;

    assign stateIn = ctrlState_e'(state);
    assign rawAll  = {raw_car, raw_dn, raw_up};

    always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < NB; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    // A non-one-hot floor code means the car position is untrustworthy, so nothing is served
    always_comb begin
        serveUp  = '0;
        serveDn  = '0;
        serveCar = '0;
        if (stateIn == ST_OPEN && $onehot(floor)) begin
            serveCar = floor;
            for (int i = 1; i <= 7; i++) serveUp[i] = floor[i] && (lastDir_q || i == 1);
            for (int i = 2; i <= 8; i++) serveDn[i] = floor[i] && (!lastDir_q || i == 8);
        end
    end

    assign serve = {serveCar, serveDn, serveUp};
    assign press = deb_q & ~debPrev_q;

`ifdef CAR_CALL_CANCEL_EN
    assign cancel = {press[NB-1:CAR_LO] & lamp_q[NB-1:CAR_LO], {CAR_LO{1'b0}}};
`else
    assign cancel = '0;
`endif

    always_comb begin
        pulse_d   = press & ~serve & ~cancel;
        lamp_d    = (lamp_q | pulse_d) & ~serve & ~cancel;
        pending_d = |lamp_d;
        lastDir_d = lastDir_q;
        case (stateIn)
            ST_UP:   lastDir_d = 1'b1;
            ST_DOWN: lastDir_d = 1'b0;
            default: lastDir_d = lastDir_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            pulse_q   <= '0;
            lamp_q    <= '0;
            pending_q <= 1'b0;
            lastDir_q <= 1'b1;
            for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
        end else begin
            sync1_q   <= rawAll;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            pulse_q   <= pulse_d;
            lamp_q    <= lamp_d;
            pending_q <= pending_d;
            lastDir_q <= lastDir_d;
            for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign btup        = pulse_q[DN_LO-1:0];
    assign btdn        = pulse_q[CAR_LO-1:DN_LO];
    assign in_bt_floor = pulse_q[NB-1:CAR_LO];
    assign lamp_up     = lamp_q[DN_LO-1:0];
    assign lamp_dn     = lamp_q[CAR_LO-1:DN_LO];
    assign lamp_car    = lamp_q[NB-1:CAR_LO];
    assign pending     = pending_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Bench for elevator_call_panel: directed scenarios plus random button traffic, checked by a scoreboard
// fed from a window-based reference model of the button conditioning and call service rules.
module tb_elevator_call_panel;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:1] raw_up;
    logic [8:2] raw_dn;
    logic [8:1] raw_car;
    logic [8:1] floor;
    logic [1:0] state;
    logic [7:1] btup;
    logic [8:2] btdn;
    logic [8:1] in_bt_floor;
    logic [7:1] lamp_up;
    logic [8:2] lamp_dn;
    logic [8:1] lamp_car;
    logic       pending;

    int testsRun = 0;
    int failures = 0;
    bit monOn    = 1'b0;

    always #5 clk = ~clk;

    elevator_call_panel #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .raw_up(raw_up), .raw_dn(raw_dn), .raw_car(raw_car),
        .floor(floor), .state(state),
        .btup(btup), .btdn(btdn), .in_bt_floor(in_bt_floor),
        .lamp_up(lamp_up), .lamp_dn(lamp_dn), .lamp_car(lamp_car),
        .pending(pending)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's level changes once its last DEB synchronised samples
    // (raw delayed two clocks) all disagree with the current level
    typedef struct {
        int          cycle;
        logic [21:0] pulses;
    } exp_t;

    exp_t        expQ[$];
    int          cycleNow = 0;
    logic [21:0] mRaw1 = '0, mRaw2 = '0, mDeb = '0, mRise = '0, mLamp = '0;
    logic [21:0] mWin [DEB];
    bit          mLastDir = 1'b1;

    function automatic logic [21:0] serveMask(input logic [8:1] fl, input logic [1:0] st, input bit dir);
        logic [7:1] u;
        logic [8:2] d;
        logic [8:1] c;
        u = '0;
        d = '0;
        c = '0;
        if (st == 2'b00 && $countones(fl) == 1) begin
            c = fl;
            for (int f = 1; f <= 7; f++) if (fl[f] && (dir || f == 1)) u[f] = 1'b1;
            for (int f = 2; f <= 8; f++) if (fl[f] && (!dir || f == 8)) d[f] = 1'b1;
        end
        return {c, d, u};
    endfunction

    always @(posedge clk) begin : model
        logic [21:0] sVal, flip, srv, cnc, pls;
        cycleNow++;
        if (!rst) begin
            mRaw1 = '0;
            mRaw2 = '0;
            for (int i = 0; i < DEB; i++) mWin[i] = '0;
            mDeb     = '0;
            mRise    = '0;
            mLamp    = '0;
            mLastDir = 1'b1;
        end else begin
            sVal  = mRaw2;
            mRaw2 = mRaw1;
            mRaw1 = {raw_car, raw_dn, raw_up};
            for (int i = 0; i < DEB - 1; i++) mWin[i] = mWin[i + 1];
            mWin[DEB-1] = sVal;
            flip = '1;
            for (int i = 0; i < DEB; i++) flip = flip & (mWin[i] ^ mDeb);
            srv = serveMask(floor, state, mLastDir);
            cnc = '0;
`ifdef CAR_CALL_CANCEL_EN
            cnc = mRise & mLamp & {8'hFF, 14'h0};
`endif
            pls   = mRise & ~srv & ~cnc;
            mLamp = (mLamp | pls) & ~srv & ~cnc;
            if (pls != '0) expQ.push_back('{cycleNow, pls});
            mRise = flip & ~mDeb;
            mDeb  = mDeb ^ flip;
            if (state == 2'b10) mLastDir = 1'b1;
            else if (state == 2'b01) mLastDir = 1'b0;
        end
    end

    // Monitor: lamps every cycle, request pulses matched in order against the expected queue
    always @(negedge clk) begin : monitor
        logic [21:0] dutPulse;
        if (monOn) begin
            dutPulse = {in_bt_floor, btdn, btup};
            checkOutput("lamps", {10'h0, lamp_car, lamp_dn, lamp_up}, {10'h0, mLamp});
            checkOutput("pending", {31'h0, pending}, {31'h0, |mLamp});
            while (expQ.size() > 0 && expQ[0].cycle < cycleNow) begin
                checkOutput("pulse missing", 32'h0, {10'h0, expQ[0].pulses});
                void'(expQ.pop_front());
            end
            if (dutPulse != '0) begin
                if (expQ.size() == 0 || expQ[0].cycle != cycleNow) begin
                    checkOutput("unexpected pulse", {10'h0, dutPulse}, 32'h0);
                end else begin
                    checkOutput("pulse", {10'h0, dutPulse}, {10'h0, expQ[0].pulses});
                    void'(expQ.pop_front());
                end
            end else if (expQ.size() > 0 && expQ[0].cycle == cycleNow) begin
                checkOutput("pulse missing", 32'h0, {10'h0, expQ[0].pulses});
                void'(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus();
        logic [21:0] r;
        r = {raw_car, raw_dn, raw_up};
        for (int b = 0; b < 22; b++) if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
        {raw_car, raw_dn, raw_up} = r;
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 5) == 0) floor = 8'($urandom);
            else floor = 8'(1 << $urandom_range(0, 7));
        end
        if ($urandom_range(0, 5) == 0) state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        rst = ($urandom_range(0, 299) != 0);
    endtask

    initial begin : stimulus
        bit   sawPulse;
        logic expLamp7, expSaw7;
        rst     = 1'b0;
        raw_up  = '0;
        raw_dn  = '0;
        raw_car = '0;
        floor   = 8'b0000_0001;
        state   = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset lamps", {10'h0, lamp_car, lamp_dn, lamp_up}, 32'h0);
        checkOutput("reset pulses", {10'h0, in_bt_floor, btdn, btup}, 32'h0);
        checkOutput("reset pending", {31'h0, pending}, 32'h0);
        @(negedge clk);
        rst   = 1'b1;
        monOn = 1'b1;

        // Car 5 press: pulse exactly 6 cycles after the first sample, lasting one cycle
        @(negedge clk);
        raw_car[5] = 1'b1;
        repeat (6) @(posedge clk);
        #1 checkOutput("car5 early", {24'h0, in_bt_floor}, 32'h0);
        @(posedge clk);
        #1 checkOutput("car5 pulse", {24'h0, in_bt_floor}, 32'h10);
        checkOutput("car5 lamp", {31'h0, lamp_car[5]}, 32'h1);
        checkOutput("car5 pending", {31'h0, pending}, 32'h1);
        @(posedge clk);
        #1 checkOutput("car5 one cycle", {24'h0, in_bt_floor}, 32'h0);
        repeat (3) @(negedge clk);
        raw_car[5] = 1'b0;

        // Two-sample glitch on up 3 is ignored
        @(negedge clk);
        raw_up[3] = 1'b1;
        repeat (2) @(negedge clk);
        raw_up[3] = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch lamp_up3", {31'h0, lamp_up[3]}, 32'h0);

        // Floor 4 up and down lamps, then door opens at floor 4 after travelling up
        raw_up[4] = 1'b1;
        raw_dn[4] = 1'b1;
        repeat (9) @(negedge clk);
        raw_up[4] = 1'b0;
        raw_dn[4] = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("lamp_up4 set", {31'h0, lamp_up[4]}, 32'h1);
        checkOutput("lamp_dn4 set", {31'h0, lamp_dn[4]}, 32'h1);
        state = 2'b00;
        floor = 8'b0000_1000;
        @(posedge clk);
        #1 checkOutput("lamp_up4 served", {31'h0, lamp_up[4]}, 32'h0);
        checkOutput("lamp_dn4 kept", {31'h0, lamp_dn[4]}, 32'h1);

        // Down 8 pressed while the door is open at floor 8: suppressed
        @(negedge clk);
        floor     = 8'b1000_0000;
        raw_dn[8] = 1'b1;
        sawPulse  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawPulse = sawPulse | btdn[8];
        end
        checkOutput("dn8 suppressed pulse", {31'h0, sawPulse}, 32'h0);
        checkOutput("dn8 suppressed lamp", {31'h0, lamp_dn[8]}, 32'h0);
        raw_dn[8] = 1'b0;

        // Reset while car 2 is held: lamps clear, held button re-presses afterwards
        state      = 2'b10;
        raw_car[2] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("car2 lamp", {31'h0, lamp_car[2]}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("mid reset lamps", {10'h0, lamp_car, lamp_dn, lamp_up}, 32'h0);
        checkOutput("mid reset pending", {31'h0, pending}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1 checkOutput("car2 post-reset early", {24'h0, in_bt_floor}, 32'h0);
        @(posedge clk);
        #1 checkOutput("car2 post-reset pulse", {24'h0, in_bt_floor}, 32'h02);
        @(negedge clk);
        raw_car[2] = 1'b0;

        // Repeat press on a lit car 7 lamp
        raw_car[7] = 1'b1;
        repeat (9) @(negedge clk);
        raw_car[7] = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("car7 first lamp", {31'h0, lamp_car[7]}, 32'h1);
        raw_car[7] = 1'b1;
        sawPulse   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawPulse = sawPulse | in_bt_floor[7];
        end
`ifdef CAR_CALL_CANCEL_EN
        expLamp7 = 1'b0;
        expSaw7  = 1'b0;
`else
        expLamp7 = 1'b1;
        expSaw7  = 1'b1;
`endif
        checkOutput("car7 repeat pulse", {31'h0, sawPulse}, {31'h0, expSaw7});
        checkOutput("car7 repeat lamp", {31'h0, lamp_car[7]}, {31'h0, expLamp7});
        raw_car[7] = 1'b0;

        // Random button traffic, floor moves, door states and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            applyStimulus();
        end
        @(negedge clk);
        rst     = 1'b1;
        raw_up  = '0;
        raw_dn  = '0;
        raw_car = '0;
        repeat (12) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
